// File: rtl/cu_alloc_selector_pkg.sv
// Shared dispatcher definitions for the CU allocation selector: width defaults,
// the selector FSM state encoding, and the CU pointer width.
package cu_alloc_selector_pkg;

  localparam int CU_ID_WIDTH   = 6;
  localparam int NUMBER_CU     = 64;
  localparam int VGPR_ID_WIDTH = 10;
  localparam int SGPR_ID_WIDTH = 9;
  localparam int LDS_ID_WIDTH  = 16;
  localparam int WF_ID_WIDTH   = 4;

  localparam int PTR_WIDTH = (NUMBER_CU > 1) ? $clog2(NUMBER_CU) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    COLLECT = 3'd2,
    PICK    = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/cu_alloc_selector_rr_priority_encoder.sv
// Combinational rotating priority encoder: finds the first set bit of mask at or
// above base, wrapping from N-1 back to 0. index is 0 when nothing is set.
module cu_alloc_selector_rr_priority_encoder #(
  parameter int N = 64,
  parameter int W = 6
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] base,
  output logic         found,
  output logic [W-1:0] index
);

  int         j;
  logic [W-1:0] jw;

  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    jw    = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(base) + i;
      if (j >= N) j = j - N;
      jw = W'(j);
      if (!found && mask[jw]) begin
        found = 1'b1;
        index = jw;
      end
    end
  end

endmodule

// File: rtl/cu_alloc_selector.sv
// Allocator front end: fans one workgroup request out to the four resource CAMs,
// ANDs their CU masks and returns one eligible CU (or no-fit) on a response channel.
// Build option: CU_ALLOC_SELECTOR_RR_EN selects round-robin instead of lowest-index-first.
module cu_alloc_selector
  import cu_alloc_selector_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [VGPR_ID_WIDTH:0]   req_vgpr_size,
  input  logic [SGPR_ID_WIDTH:0]   req_sgpr_size,
  input  logic [LDS_ID_WIDTH:0]    req_lds_size,
  input  logic [WF_ID_WIDTH:0]     req_wf_size,
  output logic                     vgpr_search_en,
  output logic                     sgpr_search_en,
  output logic                     lds_search_en,
  output logic                     wf_search_en,
  output logic [VGPR_ID_WIDTH:0]   vgpr_search_size,
  output logic [SGPR_ID_WIDTH:0]   sgpr_search_size,
  output logic [LDS_ID_WIDTH:0]    lds_search_size,
  output logic [WF_ID_WIDTH:0]     wf_search_size,
  input  logic [NUMBER_CU-1:0]     vgpr_search_out,
  input  logic [NUMBER_CU-1:0]     sgpr_search_out,
  input  logic [NUMBER_CU-1:0]     lds_search_out,
  input  logic [NUMBER_CU-1:0]     wf_search_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_found,
  output logic [CU_ID_WIDTH-1:0]   rsp_cu_id,
  output state_t                   dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid never waits on ready, and payload is held until the transfer.

  state_t               state, state_nxt;
  logic [NUMBER_CU-1:0] mask_q;
  logic [PTR_WIDTH-1:0] rr_ptr;
  logic                 pick_found;
  logic [PTR_WIDTH-1:0] pick_index;
  logic                 search_active;
  logic                 req_accept;
  logic                 rsp_accept;

  assign dbg_state = state;

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    search_active = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SEARCH;
      end
      SEARCH: begin
        search_active = 1'b1;
        state_nxt     = COLLECT;
      end
      COLLECT: state_nxt = PICK;
      PICK:    state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_accept     = req_valid & req_ready;
  assign rsp_accept     = rsp_valid & rsp_ready;
  assign vgpr_search_en = search_active;
  assign sgpr_search_en = search_active;
  assign lds_search_en  = search_active;
  assign wf_search_en   = search_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sizes are captured on accept and double as the CAM search size outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vgpr_search_size <= '0;
      sgpr_search_size <= '0;
      lds_search_size  <= '0;
      wf_search_size   <= '0;
    end else if (req_accept) begin
      vgpr_search_size <= req_vgpr_size;
      sgpr_search_size <= req_sgpr_size;
      lds_search_size  <= req_lds_size;
      wf_search_size   <= req_wf_size;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      rsp_found <= 1'b0;
      rsp_cu_id <= '0;
    end else begin
      if (state == COLLECT)
        mask_q <= vgpr_search_out & sgpr_search_out & lds_search_out & wf_search_out;
      if (state == PICK) begin
        rsp_found <= pick_found;
        rsp_cu_id <= CU_ID_WIDTH'(pick_index);
      end
    end
  end

`ifdef CU_ALLOC_SELECTOR_RR_EN
  // Pointer only advances past a CU that was actually handed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (rsp_accept && rsp_found)
      rr_ptr <= (rsp_cu_id == CU_ID_WIDTH'(NUMBER_CU - 1)) ? '0
                                                           : PTR_WIDTH'(rsp_cu_id + 1'b1);
  end
`else
  assign rr_ptr = '0;
`endif

  cu_alloc_selector_rr_priority_encoder #(
    .N (NUMBER_CU),
    .W (PTR_WIDTH)
  ) u_rr_priority_encoder (
    .mask  (mask_q),
    .base  (rr_ptr),
    .found (pick_found),
    .index (pick_index)
  );

endmodule

// File: tb/tb_cu_alloc_selector.sv
// Directed bench for cu_alloc_selector: vector table plus stall and mid-response
// reset sequences; expected CU ids are hand-computed for both selection modes.
module tb_cu_alloc_selector;
  import cu_alloc_selector_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                   clk;
  logic                   rst_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [VGPR_ID_WIDTH:0] req_vgpr_size;
  logic [SGPR_ID_WIDTH:0] req_sgpr_size;
  logic [LDS_ID_WIDTH:0]  req_lds_size;
  logic [WF_ID_WIDTH:0]   req_wf_size;
  logic                   vgpr_search_en, sgpr_search_en, lds_search_en, wf_search_en;
  logic [VGPR_ID_WIDTH:0] vgpr_search_size;
  logic [SGPR_ID_WIDTH:0] sgpr_search_size;
  logic [LDS_ID_WIDTH:0]  lds_search_size;
  logic [WF_ID_WIDTH:0]   wf_search_size;
  logic [NUMBER_CU-1:0]   vgpr_search_out, sgpr_search_out, lds_search_out, wf_search_out;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_found;
  logic [CU_ID_WIDTH-1:0] rsp_cu_id;
  state_t                 dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // CAM model: a mask is returned only in the cycle after its search strobe.
  logic [63:0] cur_vm, cur_sm, cur_lm, cur_wm;
  logic        vgpr_live, sgpr_live, lds_live, wf_live;

  typedef struct {
    logic [63:0]            vm, sm, lm, wm;
    logic [VGPR_ID_WIDTH:0] vs;
    logic [SGPR_ID_WIDTH:0] ss;
    logic [LDS_ID_WIDTH:0]  ls;
    logic [WF_ID_WIDTH:0]   ws;
    logic                   ef;
    logic [5:0]             id_fix;
    logic [5:0]             id_rr;
  } vec_t;

  vec_t vecs[12];

  cu_alloc_selector dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_vgpr_size    (req_vgpr_size),
    .req_sgpr_size    (req_sgpr_size),
    .req_lds_size     (req_lds_size),
    .req_wf_size      (req_wf_size),
    .vgpr_search_en   (vgpr_search_en),
    .sgpr_search_en   (sgpr_search_en),
    .lds_search_en    (lds_search_en),
    .wf_search_en     (wf_search_en),
    .vgpr_search_size (vgpr_search_size),
    .sgpr_search_size (sgpr_search_size),
    .lds_search_size  (lds_search_size),
    .wf_search_size   (wf_search_size),
    .vgpr_search_out  (vgpr_search_out),
    .sgpr_search_out  (sgpr_search_out),
    .lds_search_out   (lds_search_out),
    .wf_search_out    (wf_search_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_found        (rsp_found),
    .rsp_cu_id        (rsp_cu_id),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vgpr_live <= 1'b0; sgpr_live <= 1'b0; lds_live <= 1'b0; wf_live <= 1'b0;
    end else begin
      vgpr_live <= vgpr_search_en; sgpr_live <= sgpr_search_en;
      lds_live  <= lds_search_en;  wf_live   <= wf_search_en;
    end
  end

  assign vgpr_search_out = vgpr_live ? cur_vm : '0;
  assign sgpr_search_out = sgpr_live ? cur_sm : '0;
  assign lds_search_out  = lds_live  ? cur_lm : '0;
  assign wf_search_out   = wf_live   ? cur_wm : '0;

  // scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_masks(input logic [63:0] vm, sm, lm, wm);
    cur_vm = vm; cur_sm = sm; cur_lm = lm; cur_wm = wm;
  endtask

  task automatic start_req(input logic [VGPR_ID_WIDTH:0] vs, input logic [SGPR_ID_WIDTH:0] ss,
                           input logic [LDS_ID_WIDTH:0] ls, input logic [WF_ID_WIDTH:0] ws);
    int w;
    req_vgpr_size = vs; req_sgpr_size = ss; req_lds_size = ls; req_wf_size = ws;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("accept_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("search_en", {60'd0, vgpr_search_en, sgpr_search_en, lds_search_en, wf_search_en}, 64'hF);
    chk("search_size", {vgpr_search_size, sgpr_search_size, lds_search_size, wf_search_size},
        {vs, ss, ls, ws});
    chk("busy_ready", {63'd0, req_ready}, 64'd0);
  endtask

  task automatic wait_rsp();
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
      if (lat == 1)
        chk("search_en_drop", {60'd0, vgpr_search_en, sgpr_search_en, lds_search_en, wf_search_en}, 64'h0);
    end
    chk("rsp_latency", 64'(lat), 64'd3);
  endtask

  task automatic do_req(input vec_t v, input logic [5:0] exp_id);
    set_masks(v.vm, v.sm, v.lm, v.wm);
    rsp_ready = 1'b1;
    start_req(v.vs, v.ss, v.ls, v.ws);
    wait_rsp();
    chk("rsp_found", {63'd0, rsp_found}, {63'd0, v.ef});
    chk("rsp_cu_id", {58'd0, rsp_cu_id}, {58'd0, exp_id});
    @(posedge clk); #1;
    chk("post_hs", {62'd0, rsp_valid, req_ready}, 64'b01);
  endtask

  function automatic logic [5:0] pick_id(input logic [5:0] id_fix, input logic [5:0] id_rr);
`ifdef CU_ALLOC_SELECTOR_RR_EN
    return id_rr;
`else
    return id_fix;
`endif
  endfunction

  logic [5:0] held_id;
  logic       held_found;

  initial begin
    vecs[0]  = '{ONES, ONES, ONES, ONES, 11'd1, 10'd2, 17'd3, 5'd4, 1'b1, 6'd0, 6'd0};
    vecs[1]  = '{ONES, ONES, ONES, ONES, 11'd10, 10'd20, 17'd30, 5'd1, 1'b1, 6'd0, 6'd1};
    vecs[2]  = '{ONES, ONES, ONES, ONES, 11'h7FF, 10'h3FF, 17'h1FFFF, 5'h1F, 1'b1, 6'd0, 6'd2};
    vecs[3]  = '{ONES, ONES, ONES, ONES, 11'h400, 10'h200, 17'h10000, 5'h10, 1'b1, 6'd0, 6'd3};
    vecs[4]  = '{64'h0F, 64'h0C, 64'h0A, ONES, 11'd5, 10'd6, 17'd7, 5'd8, 1'b1, 6'd3, 6'd3};
    vecs[5]  = '{ONES, ONES, 64'h0, ONES, 11'd9, 10'd9, 17'd9, 5'd9, 1'b0, 6'd0, 6'd0};
    vecs[6]  = '{ONES, ONES, ONES, ONES, 11'd2, 10'd2, 17'd2, 5'd2, 1'b1, 6'd0, 6'd4};
    vecs[7]  = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
                 64'h4000_0000_0000_0000, 11'd3, 10'd3, 17'd3, 5'd3, 1'b1, 6'd62, 6'd62};
    vecs[8]  = '{64'h8000_0000_0000_0020, 64'h8000_0000_0000_0020, 64'h8000_0000_0000_0020,
                 64'h8000_0000_0000_0020, 11'd4, 10'd4, 17'd4, 5'd4, 1'b1, 6'd5, 6'd63};
    vecs[9]  = '{64'h8000_0000_0000_0020, 64'h8000_0000_0000_0020, 64'h8000_0000_0000_0020,
                 64'h8000_0000_0000_0020, 11'd4, 10'd4, 17'd4, 5'd4, 1'b1, 6'd5, 6'd5};
    vecs[10] = '{64'hFFFF_0000_0000_0000, ONES, 64'h00F0_0000_0000_0000, ONES,
                 11'd100, 10'd50, 17'd1000, 5'd7, 1'b1, 6'd52, 6'd52};
    vecs[11] = '{64'h1000_0000_0000_0002, 64'h1000_0000_0000_0002, 64'h1000_0000_0000_0002,
                 64'h1000_0000_0000_0002, 11'd8, 10'd8, 17'd8, 5'd8, 1'b1, 6'd1, 6'd60};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_vgpr_size = '0; req_sgpr_size = '0; req_lds_size = '0; req_wf_size = '0;
    set_masks(ONES, ONES, ONES, ONES);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_valid", {62'd0, req_ready, rsp_valid}, 64'b10);
    chk("rst_found_id", {57'd0, rsp_found, rsp_cu_id}, 64'd0);
    chk("rst_sizes", {vgpr_search_size, sgpr_search_size, lds_search_size, wf_search_size}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_state", 64'(dbg_state), 64'(IDLE));
    chk("idle_search_en", {60'd0, vgpr_search_en, sgpr_search_en, lds_search_en, wf_search_en}, 64'h0);

    for (int i = 0; i < 12; i++)
      do_req(vecs[i], pick_id(vecs[i].id_fix, vecs[i].id_rr));

    // Response stalled for 10 cycles while a second request waits.
    set_masks(ONES, ONES, ONES, ONES);
    rsp_ready = 1'b0;
    start_req(11'd11, 10'd12, 17'd13, 5'd14);
    wait_rsp();
    held_found = rsp_found;
    held_id    = rsp_cu_id;
    chk("stall_found", {63'd0, held_found}, 64'd1);
    chk("stall_id", {58'd0, held_id}, {58'd0, pick_id(6'd0, 6'd61)});
    req_vgpr_size = 11'd21; req_sgpr_size = 10'd22; req_lds_size = 17'd23; req_wf_size = 5'd24;
    req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("stall_hold", {56'd0, rsp_valid, req_ready, rsp_found, rsp_cu_id[4:0]},
          {56'd0, 1'b1, 1'b0, held_found, held_id[4:0]});
      chk("stall_id_hi", {63'd0, rsp_cu_id[5]}, {63'd0, held_id[5]});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall_release_ready", {62'd0, rsp_valid, req_ready}, 64'b01);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pending_accepted", {60'd0, vgpr_search_en, sgpr_search_en, lds_search_en, wf_search_en}, 64'hF);
    chk("pending_size", {vgpr_search_size, sgpr_search_size, lds_search_size, wf_search_size},
        {11'd21, 10'd22, 17'd23, 5'd24});
    wait_rsp();
    chk("pending_id", {58'd0, rsp_cu_id}, {58'd0, pick_id(6'd0, 6'd62)});

    // Reset while the response is still waiting for rsp_ready.
    rst_n = 1'b0;
    #1;
    chk("midrst_ready_valid", {62'd0, req_ready, rsp_valid}, 64'b10);
    chk("midrst_found_id", {57'd0, rsp_found, rsp_cu_id}, 64'd0);
    chk("midrst_sizes", {vgpr_search_size, sgpr_search_size, lds_search_size, wf_search_size}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(vecs[0], 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
